tdc_fifo_arbiter: RTL and testbench
===================================

TDC_FIFO_ARBITER -- requirements
Module: tdc_fifo_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of write channels, 1..8.
REQ-002 SHALL have parameter DW, default 40: data bits per channel word.
REQ-003 SHALL have parameter TAGW, default 8: tag bits prepended to each word; TAGW+DW SHALL be a multiple of 8; NB=(TAGW+DW)/8.
REQ-004 SHALL have parameter AW, default 4: FIFO depth is 2^AW words.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 wr_en  in  NCH  per-channel write request, held high until wr_ack.
REQ-008 din  in  NCH*DW  channel c data at bits [c*DW +: DW].
REQ-009 wr_ack  out  NCH  one-cycle pulse: word stored.
REQ-010 wr_drop  out  NCH  one-cycle pulse: word discarded, FIFO full.
REQ-011 tx_busy  in  1  serial transmitter busy.
REQ-012 tx_new  out  1  one-cycle strobe: tx_data valid for transmitter.
REQ-013 tx_data  out  8  byte to transmit.
REQ-014 empty, full  out  1 each  FIFO status.
REQ-015 level  out  AW+1  words held, 0..2^AW.
REQ-016 drop_count  out  16  saturating count of dropped words.

Function
REQ-017 Write arbitration SHALL be round-robin: each cycle grant at most one requesting channel, searching from (last granted + 1) mod NCH; after reset the search starts at channel 0.
REQ-018 A channel whose wr_ack or wr_drop is high in the current cycle SHALL be masked from arbitration that cycle.
REQ-019 Grant at edge k with full=0: store {TAGW'(c), din[c]} (tag = channel index, zero-extended, in the MSBs); wr_ack[c] high for the cycle after edge k.
REQ-020 Grant at edge k with full=1: discard word, wr_drop[c] pulse after edge k, drop_count+1, saturating at 16'hFFFF; full is evaluated before any same-edge pop.
REQ-021 Non-granted requests SHALL remain pending, neither acknowledged nor dropped.
REQ-022 Read FSM SHALL have states IDLE, LOAD, SEND, WAIT.
REQ-023 IDLE: if empty=0, pop one word and go to LOAD; else stay.
REQ-024 LOAD: capture popped word in shift register, byte index 0, go to SEND.
REQ-025 SEND: when tx_busy=0 and tx_new=0, drive tx_new=1 for one cycle with tx_data = current byte (MSB byte first), go to WAIT; else hold.
REQ-026 WAIT: one guard cycle covering the transmitter's busy-assert latency; then go to IDLE if byte index = NB-1, else increment index and go to SEND.
REQ-027 Push and pop on the same edge SHALL leave level unchanged; pointers SHALL wrap modulo 2^AW.
REQ-028 full = (level == 2^AW); empty = (level == 0); both SHALL be registered and consistent with level.
REQ-029 Latency: a word written at edge k into an empty FIFO SHALL produce its first tx_new after edge k+3 if tx_busy=0.
REQ-030 tx_data SHALL hold its value from a tx_new strobe until the next strobe.

Reset
REQ-031 On rst=1, asynchronously: FIFO empty, level=0, empty=1, full=0, FSM=IDLE, tx_new=0, tx_data=0, wr_ack=0, wr_drop=0, drop_count=0, round-robin pointer=channel 0.
REQ-032 Reset mid-transmission SHALL abandon the current word and all stored words; after release, no tx_new until a new write.

Verification
REQ-033 NCH=2: ch0 din=40'h0102030405 at edge 1, tx_busy=0 -> wr_ack[0] after edge 1; tx_data bytes 00,01,02,03,04,05 in order, first tx_new after edge 4.
REQ-034 Both channels request continuously for 4 grants -> acks alternate ch0,ch1,ch0,ch1; stored tags 00,01,00,01.
REQ-035 AW=2, tx_busy=1, 5 writes on ch1 -> 4 acks, full=1, level=4; 5th yields wr_drop[1], drop_count=1.
REQ-036 Full FIFO, new write on the same edge as a pop -> write dropped, level 4->3.
REQ-037 tx_busy held high during SEND -> no tx_new; releasing tx_busy -> tx_new next cycle, no byte lost or repeated.
REQ-038 rst pulsed after 2nd byte of a word -> tx_new stops, level=0, empty=1, drop_count=0.

Source files
------------

// File: rtl/tdc_fifo_arbiter_if.sv
// Channel-write, FIFO-status and byte-transmitter signals of tdc_fifo_arbiter.
// The master side drives the write requests and the transmitter busy flag;
// the slave side (the arbiter) drives acknowledges, status and the byte strobe.
interface tdc_fifo_arbiter_if #(
    parameter int NCH = 2,
    parameter int DW  = 40,
    parameter int AW  = 4
);
    logic [NCH-1:0]    wr_en;
    logic [NCH*DW-1:0] din;
    logic [NCH-1:0]    wr_ack;
    logic [NCH-1:0]    wr_drop;
    logic              tx_busy;
    logic              tx_new;
    logic [7:0]        tx_data;
    logic              empty;
    logic              full;
    logic [AW:0]       level;
    logic [15:0]       drop_count;

    modport master (
        output wr_en, din, tx_busy,
        input  wr_ack, wr_drop, tx_new, tx_data, empty, full, level, drop_count
    );

    modport slave (
        input  wr_en, din, tx_busy,
        output wr_ack, wr_drop, tx_new, tx_data, empty, full, level, drop_count
    );
endinterface

// File: rtl/tdc_fifo_arbiter.sv
// Round-robin multi-channel writer into a tagged word FIFO, drained one byte
// at a time (MSB byte first) towards a serial transmitter. Words that win
// arbitration while the FIFO is full are dropped and counted.
module tdc_fifo_arbiter #(
    parameter int NCH  = 2,
    parameter int DW   = 40,
    parameter int TAGW = 8,
    parameter int AW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    tdc_fifo_arbiter_if.slave  bus
);
    localparam int WW    = TAGW + DW;
    localparam int NB    = WW / 8;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    // storage and status
    logic [WW-1:0]  mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    level_r;
    logic [AW:0]    level_nxt_s;
    logic           full_r;
    logic           empty_r;
    logic [15:0]    drop_count_r;

    // arbitration
    logic [CW-1:0]  rr_ptr_r;
    logic [CW-1:0]  rr_nxt_s;
    logic [CW-1:0]  cand_s;
    logic [NCH-1:0] req_s;
    logic           grant_vld_s;
    logic [CW-1:0]  grant_idx_s;
    logic [NCH-1:0] wr_ack_r;
    logic [NCH-1:0] wr_drop_r;
    logic           push_s;
    logic           drop_s;
    logic [WW-1:0]  push_word_s;

    // read side
    state_t         state_r;
    state_t         state_nxt_s;
    logic           pop_s;
    logic           load_s;
    logic           send_s;
    logic           advance_s;
    logic [WW-1:0]  pop_word_r;
    logic [WW-1:0]  shift_r;
    logic [BW-1:0]  byte_idx_r;
    logic           tx_new_r;
    logic [7:0]     tx_data_r;

    // Round-robin search starting at rr_ptr_r; channels just acked/dropped sit out
    always_comb begin
        req_s       = bus.wr_en & ~wr_ack_r & ~wr_drop_r;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = rr_ptr_r;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_vld_s && req_s[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
            if (cand_s == CW'(NCH - 1)) begin
                cand_s = '0;
            end else begin
                cand_s = cand_s + 1'b1;
            end
        end
        if (grant_idx_s == CW'(NCH - 1)) begin
            rr_nxt_s = '0;
        end else begin
            rr_nxt_s = grant_idx_s + 1'b1;
        end
    end

    // A grant is stored unless the FIFO was already full before this edge
    assign push_s      = grant_vld_s & ~full_r;
    assign drop_s      = grant_vld_s & full_r;
    assign push_word_s = {TAGW'(grant_idx_s), bus.din[int'(grant_idx_s) * DW +: DW]};

    // Occupancy after this edge's push/pop
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + {{AW{1'b0}}, 1'b1};
            2'b01:   level_nxt_s = level_r - {{AW{1'b0}}, 1'b1};
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end
    end

    // Pointers, status flags, write handshakes and the drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            drop_count_r <= 16'd0;
            rr_ptr_r     <= '0;
            wr_ack_r     <= '0;
            wr_drop_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            level_r   <= level_nxt_s;
            full_r    <= (level_nxt_s == (AW + 1)'(DEPTH));
            empty_r   <= (level_nxt_s == '0);
            wr_ack_r  <= '0;
            wr_drop_r <= '0;
            if (grant_vld_s) begin
                rr_ptr_r <= rr_nxt_s;
                if (full_r) begin
                    wr_drop_r[grant_idx_s] <= 1'b1;
                end else begin
                    wr_ack_r[grant_idx_s] <= 1'b1;
                end
            end
            if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_r) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: state_nxt_s = SEND;
            SEND: begin
                if (!bus.tx_busy && !tx_new_r) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            WAIT: begin
                if (byte_idx_r == BW'(NB - 1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read FSM datapath controls
    always_comb begin
        pop_s     = 1'b0;
        load_s    = 1'b0;
        send_s    = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            IDLE:    pop_s     = ~empty_r;
            LOAD:    load_s    = 1'b1;
            SEND:    send_s    = ~bus.tx_busy & ~tx_new_r;
            WAIT:    advance_s = (byte_idx_r != BW'(NB - 1));
            default: pop_s     = 1'b0;
        endcase
    end

    // Word capture, byte sequencing and the transmitter strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_word_r <= '0;
            shift_r    <= '0;
            byte_idx_r <= '0;
            tx_new_r   <= 1'b0;
            tx_data_r  <= 8'd0;
        end else begin
            if (pop_s) begin
                pop_word_r <= mem_r[rd_ptr_r];
            end
            if (load_s) begin
                shift_r    <= pop_word_r;
                byte_idx_r <= '0;
            end else if (advance_s) begin
                shift_r    <= shift_r << 8;
                byte_idx_r <= byte_idx_r + 1'b1;
            end
            tx_new_r <= send_s;
            if (send_s) begin
                tx_data_r <= shift_r[WW-1 -: 8];
            end
        end
    end

    assign bus.wr_ack     = wr_ack_r;
    assign bus.wr_drop    = wr_drop_r;
    assign bus.tx_new     = tx_new_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.empty      = empty_r;
    assign bus.full       = full_r;
    assign bus.level      = level_r;
    assign bus.drop_count = drop_count_r;
endmodule

// File: tb/tb_tdc_fifo_arbiter.sv
// Bench for tdc_fifo_arbiter: a queue-based reference model predicts every
// output each cycle; directed scenarios pin the model with literal values.
module tb_tdc_fifo_arbiter;
    localparam int NCH   = 2;
    localparam int DW    = 40;
    localparam int TAGW  = 8;
    localparam int AW    = 2;
    localparam int WW    = TAGW + DW;
    localparam int NB    = WW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // free-running clock
    always #5 clk = ~clk;

    tdc_fifo_arbiter_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus ();

    tdc_fifo_arbiter #(.NCH(NCH), .DW(DW), .TAGW(TAGW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ecount = 0;

    // reference model state
    logic [WW-1:0]  m_q[$];
    logic [7:0]     m_bytes[$];
    int             m_edge = 0;
    int             m_earliest = 0;
    int             m_idle_from = 0;
    int             m_rr = 0;
    int             m_dropcnt = 0;
    logic [NCH-1:0] m_ack = '0;
    logic [NCH-1:0] m_drop = '0;
    logic           m_txnew = 1'b0;
    logic [7:0]     m_txdata = 8'd0;

    // captured DUT activity for directed checks
    logic [7:0]     cap_b[$];
    int             cap_e[$];
    logic [NCH-1:0] ack_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model: reader pops a word when idle,
    // emits one byte per allowed slot, writer grants one channel round-robin.
    task automatic model_edge();
        int             pre;
        int             g;
        int             c;
        logic [NCH-1:0] req;
        logic [WW-1:0]  w;
        logic           do_pop;
        logic           do_emit;
        m_edge++;
        if (rst) begin
            m_q.delete();
            m_bytes.delete();
            m_idle_from = 0;
            m_earliest  = 0;
            m_rr        = 0;
            m_dropcnt   = 0;
            m_ack       = '0;
            m_drop      = '0;
            m_txnew     = 1'b0;
            m_txdata    = 8'd0;
        end else begin
            pre     = m_q.size();
            do_pop  = (m_bytes.size() == 0) && (m_edge >= m_idle_from) && (pre > 0);
            do_emit = (m_bytes.size() > 0) && (m_edge >= m_earliest) && !bus.tx_busy;
            req     = bus.wr_en & ~m_ack & ~m_drop;
            g = -1;
            for (int i = 0; i < NCH; i++) begin
                c = (m_rr + i) % NCH;
                if (g < 0 && req[c]) g = c;
            end
            m_ack   = '0;
            m_drop  = '0;
            m_txnew = 1'b0;
            if (do_pop) begin
                w = m_q.pop_front();
                for (int b = NB - 1; b >= 0; b--) m_bytes.push_back(w[b*8 +: 8]);
                m_earliest = m_edge + 2;
            end
            if (do_emit) begin
                m_txdata   = m_bytes.pop_front();
                m_txnew    = 1'b1;
                m_earliest = m_edge + 2;
                if (m_bytes.size() == 0) m_idle_from = m_edge + 2;
            end
            if (g >= 0) begin
                m_rr = (g + 1) % NCH;
                if (pre == DEPTH) begin
                    m_drop[g] = 1'b1;
                    if (m_dropcnt < 65535) m_dropcnt++;
                end else begin
                    w = {TAGW'(g), bus.din[g*DW +: DW]};
                    m_q.push_back(w);
                    m_ack[g] = 1'b1;
                end
            end
        end
    endtask

    // model advances on every rising edge
    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // advance to the next falling edge and compare every output with the model
    task automatic step();
        @(negedge clk);
        ecount++;
        chk("wr_ack", bus.wr_ack, m_ack);
        chk("wr_drop", bus.wr_drop, m_drop);
        chk("tx_new", bus.tx_new, m_txnew);
        chk("tx_data", bus.tx_data, m_txdata);
        chk("level", bus.level, m_q.size());
        chk("full", bus.full, (m_q.size() == DEPTH));
        chk("empty", bus.empty, (m_q.size() == 0));
        chk("drop_count", bus.drop_count, m_dropcnt);
        if (bus.tx_new === 1'b1) begin
            cap_b.push_back(bus.tx_data);
            cap_e.push_back(ecount);
        end
        if (bus.wr_ack !== '0) ack_log.push_back(bus.wr_ack);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_en = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // n sequential writes on channel 1, each held until acked or dropped
    task automatic fill_ch1(input int n, output int acks, output int drops);
        acks  = 0;
        drops = 0;
        for (int w = 0; w < n; w++) begin
            bus.din[DW +: DW] = 40'hC000000000 + DW'(w);
            bus.wr_en[1] = 1'b1;
            for (int t = 0; t < 10; t++) begin
                step();
                if (bus.wr_ack[1] === 1'b1) begin
                    acks++;
                    break;
                end else if (bus.wr_drop[1] === 1'b1) begin
                    drops++;
                    break;
                end
            end
            bus.wr_en[1] = 1'b0;
        end
    endtask

    // randomized channel masters and transmitter busy
    task automatic drive_random(input int p_req, input int p_busy);
        for (int c = 0; c < NCH; c++) begin
            if (bus.wr_en[c] && (m_ack[c] || m_drop[c])) begin
                bus.wr_en[c] = ($urandom_range(0, 99) < 50);
                bus.din[c*DW +: DW] = DW'({$urandom(), $urandom()});
            end else if (!bus.wr_en[c] && ($urandom_range(0, 99) < p_req)) begin
                bus.wr_en[c] = 1'b1;
                bus.din[c*DW +: DW] = DW'({$urandom(), $urandom()});
            end
        end
        bus.tx_busy = ($urandom_range(0, 99) < p_busy);
    endtask

    logic [7:0] exp_a [NB] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] exp_e [NB] = '{8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    logic [NCH-1:0] exp_b_ack [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] exp_b_tag [4] = '{8'h00, 8'h01, 8'h00, 8'h01};
    int p_req_tab [4]  = '{20, 90, 60, 100};
    int p_busy_tab [4] = '{10, 70, 40, 90};

    // directed scenarios followed by randomized traffic
    initial begin
        int base;
        int acks;
        int drops;
        int done;
        bus.wr_en   = '0;
        bus.din     = '0;
        bus.tx_busy = 1'b0;
        step();
        step();
        chk("rst_level", bus.level, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        rst = 1'b0;

        // single word latency and byte order
        bus.din[0 +: DW] = 40'h0102030405;
        bus.wr_en = 2'b01;
        base = ecount;
        cap_b.delete();
        cap_e.delete();
        step();
        chk("A_ack", bus.wr_ack, 2'b01);
        bus.wr_en = '0;
        repeat (20) step();
        chk("A_nbytes", cap_b.size(), NB);
        if (cap_b.size() >= NB) begin
            for (int b = 0; b < NB; b++) chk("A_byte", cap_b[b], exp_a[b]);
            chk("A_first_edge", cap_e[0] - base, 4);
        end

        // two channels requesting continuously alternate
        do_reset();
        bus.tx_busy = 1'b1;
        bus.din = {40'h2222222222, 40'h1111111111};
        bus.wr_en = 2'b11;
        ack_log.delete();
        for (int t = 0; t < 20 && ack_log.size() < 4; t++) step();
        bus.wr_en = '0;
        chk("B_nacks", ack_log.size(), 4);
        if (ack_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("B_ack_order", ack_log[i], exp_b_ack[i]);
        end
        bus.tx_busy = 1'b0;
        cap_b.delete();
        repeat (80) step();
        chk("B_nbytes", cap_b.size(), 4 * NB);
        if (cap_b.size() >= 4 * NB) begin
            for (int i = 0; i < 4; i++) chk("B_tag", cap_b[i*NB], exp_b_tag[i]);
        end

        // fill to full with the reader stalled, then overflow once
        do_reset();
        bus.tx_busy = 1'b1;
        fill_ch1(1, acks, drops);
        step();
        step();
        fill_ch1(5, acks, drops);
        chk("C_acks", acks, 4);
        chk("C_drops", drops, 1);
        chk("C_full", bus.full, 1);
        chk("C_level", bus.level, 4);
        chk("C_drop_count", bus.drop_count, 1);

        // write into a full FIFO on the same edge as a pop
        bus.tx_busy = 1'b0;
        done = 0;
        for (int t = 0; t < 40 && done == 0; t++) begin
            if (m_bytes.size() == 0 && (m_edge + 1) >= m_idle_from && m_q.size() == DEPTH) begin
                bus.din[DW +: DW] = 40'hDDDDDDDDDD;
                bus.wr_en[1] = 1'b1;
                step();
                bus.wr_en[1] = 1'b0;
                chk("D_drop", bus.wr_drop, 2'b10);
                chk("D_ack", bus.wr_ack, 2'b00);
                chk("D_level", bus.level, 3);
                chk("D_drop_count", bus.drop_count, 2);
                done = 1;
            end else begin
                step();
            end
        end
        chk("D_reached", done, 1);

        // transmitter busy holds the byte; release sends it next cycle
        do_reset();
        bus.tx_busy = 1'b1;
        bus.din[0 +: DW] = 40'hA1B2C3D4E5;
        bus.wr_en = 2'b01;
        step();
        bus.wr_en = '0;
        cap_b.delete();
        repeat (12) step();
        chk("E_quiet", cap_b.size(), 0);
        bus.tx_busy = 1'b0;
        step();
        chk("E_tx_new", bus.tx_new, 1);
        chk("E_tx_data", bus.tx_data, 8'h00);
        repeat (20) step();
        chk("E_nbytes", cap_b.size(), NB);
        if (cap_b.size() >= NB) begin
            for (int b = 0; b < NB; b++) chk("E_byte", cap_b[b], exp_e[b]);
        end

        // reset in the middle of a word
        do_reset();
        bus.tx_busy = 1'b1;
        fill_ch1(6, acks, drops);
        chk("F_pre_drop", bus.drop_count, 1);
        bus.tx_busy = 1'b0;
        cap_b.delete();
        for (int t = 0; t < 20 && cap_b.size() < 2; t++) step();
        chk("F_two_bytes", cap_b.size(), 2);
        rst = 1'b1;
        step();
        chk("F_tx_new", bus.tx_new, 0);
        chk("F_level", bus.level, 0);
        chk("F_empty", bus.empty, 1);
        chk("F_drop_count", bus.drop_count, 0);
        rst = 1'b0;
        cap_b.delete();
        repeat (20) step();
        chk("F_quiet", cap_b.size(), 0);

        // randomized traffic across load profiles
        do_reset();
        for (int blk = 0; blk < 4; blk++) begin
            for (int t = 0; t < 800; t++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    drive_random(p_req_tab[blk], p_busy_tab[blk]);
                    step();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
